// File: rtl/exec_simd_alu.sv
// Lane-split SIMD execute ALU with result-history operand forwarding.
// Define EXEC_SIMD_ALU_MUL_EN to build the iterative shift-add MUL and BUSY state.
module exec_simd_alu #(
  parameter int LANE_W = 32,
  parameter int LANES = 4,
  parameter int FWD_DEPTH = 3,
  parameter int TAG_W = 5,
  localparam int DW = LANE_W * LANES,
  localparam int SW = $clog2(FWD_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [SW-1:0]    fwd_sel_a,
  input  logic [SW-1:0]    fwd_sel_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);

  localparam int SHW = $clog2(LANE_W);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_ANDN = 4'd10;
  localparam logic [3:0] OP_SGE  = 4'd11;
  localparam logic [3:0] OP_SGEU = 4'd12;
  localparam logic [3:0] OP_SEQ  = 4'd13;
  localparam logic [3:0] OP_SNE  = 4'd14;
  localparam logic [3:0] OP_MUL  = 4'd15;

  logic [DW-1:0] hist [FWD_DEPTH];
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic [DW-1:0] alu;
  logic          hs;
  logic          acc;
  logic          is_mul;

  assign hs     = out_valid && out_ready;
  assign is_mul = in_op == OP_MUL;
  assign acc    = in_valid && in_ready;

  // Out-of-range selects fall through to zero.
  always_comb begin
    opa = '0;
    opb = '0;
    if (fwd_sel_a == '0) opa = in_a;
    if (fwd_sel_b == '0) opb = in_b;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      if (fwd_sel_a == SW'(k + 1)) opa = hist[k];
      if (fwd_sel_b == SW'(k + 1)) opb = hist[k];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] la;
    logic [LANE_W-1:0] lb;
    logic [LANE_W-1:0] r;
    logic [SHW-1:0]    sh;

    assign la = opa[g*LANE_W +: LANE_W];
    assign lb = opb[g*LANE_W +: LANE_W];
    assign sh = lb[SHW-1:0];
    assign alu[g*LANE_W +: LANE_W] = r;

    always_comb begin
      r = '0;
      unique case (in_op)
        OP_AND:  r = la & lb;
        OP_OR:   r = la | lb;
        OP_XOR:  r = la ^ lb;
        OP_ADD:  r = la + lb;
        OP_SUB:  r = la - lb;
        OP_SLT:  r = LANE_W'($signed(la) < $signed(lb));
        OP_SLTU: r = LANE_W'(la < lb);
        OP_SLL:  r = la << sh;
        OP_SRL:  r = la >> sh;
        OP_SRA:  r = $unsigned($signed(la) >>> sh);
        OP_ANDN: r = la & ~lb;
        OP_SGE:  r = LANE_W'($signed(la) >= $signed(lb));
        OP_SGEU: r = LANE_W'(la >= lb);
        OP_SEQ:  r = LANE_W'(la == lb);
        OP_SNE:  r = LANE_W'(la != lb);
        default: r = '0;
      endcase
    end
  end

`ifdef EXEC_SIMD_ALU_MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [SHW-1:0] LAST = SHW'(LANE_W - 1);

  state_t           state;
  logic [DW-1:0]    m_acc;
  logic [DW-1:0]    m_cand;
  logic [DW-1:0]    m_plr;
  logic [DW-1:0]    step_acc;
  logic [DW-1:0]    step_cand;
  logic [DW-1:0]    step_plr;
  logic [SHW-1:0]   m_cnt;
  logic [TAG_W-1:0] m_tag;

  // One shift-add step per lane: multiplicand climbs, multiplier drains.
  for (genvar g = 0; g < LANES; g++) begin : g_mul
    assign step_acc[g*LANE_W +: LANE_W] =
      m_acc[g*LANE_W +: LANE_W] +
      (m_plr[g*LANE_W] ? m_cand[g*LANE_W +: LANE_W] : '0);
    assign step_cand[g*LANE_W +: LANE_W] =
      m_cand[g*LANE_W +: LANE_W] << 1;
    assign step_plr[g*LANE_W +: LANE_W] =
      m_plr[g*LANE_W +: LANE_W] >> 1;
  end

  assign busy = state == BUSY;
  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
`else
  assign busy = 1'b0;
  assign in_ready = (!out_valid || out_ready) && !flush;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
      for (int k = 0; k < FWD_DEPTH; k++) hist[k] <= '0;
`ifdef EXEC_SIMD_ALU_MUL_EN
      state  <= IDLE;
      m_acc  <= '0;
      m_cand <= '0;
      m_plr  <= '0;
      m_cnt  <= '0;
      m_tag  <= '0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
      for (int k = 0; k < FWD_DEPTH; k++) hist[k] <= '0;
`ifdef EXEC_SIMD_ALU_MUL_EN
      state <= IDLE;
`endif
    end else begin
      if (hs) begin
        out_valid <= 1'b0;
        hist[0]   <= out_result;
        for (int k = 1; k < FWD_DEPTH; k++) hist[k] <= hist[k-1];
      end
`ifdef EXEC_SIMD_ALU_MUL_EN
      if (acc && is_mul) begin
        state  <= BUSY;
        m_acc  <= '0;
        m_cand <= opa;
        m_plr  <= opb;
        m_cnt  <= '0;
        m_tag  <= in_tag;
      end else if (acc) begin
        out_valid  <= 1'b1;
        out_result <= alu;
        out_tag    <= in_tag;
        out_err    <= 1'b0;
      end
      if (state == BUSY) begin
        m_acc  <= step_acc;
        m_cand <= step_cand;
        m_plr  <= step_plr;
        m_cnt  <= m_cnt + 1'b1;
        if (m_cnt == LAST) begin
          out_valid  <= 1'b1;
          out_result <= step_acc;
          out_tag    <= m_tag;
          out_err    <= 1'b0;
          state      <= IDLE;
        end
      end
`else
      if (acc) begin
        out_valid  <= 1'b1;
        out_result <= alu;
        out_tag    <= in_tag;
        out_err    <= is_mul;
      end
`endif
    end
  end

endmodule

// File: tb/tb_exec_simd_alu.sv
// Bench for exec_simd_alu: directed vector table, corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_exec_simd_alu;

  localparam int LW = 32;
  localparam int NL = 4;
  localparam int FD = 4;
  localparam int TW = 5;
  localparam int DW = LW * NL;
  localparam int SW = $clog2(FD + 1);
`ifdef EXEC_SIMD_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready;
  logic [3:0]    in_op;
  logic [DW-1:0] in_a, in_b;
  logic [TW-1:0] in_tag;
  logic [SW-1:0] fwd_sel_a, fwd_sel_b;
  logic          out_valid, out_ready, out_err, busy;
  logic [DW-1:0] out_result;
  logic [TW-1:0] out_tag;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  exec_simd_alu #(
    .LANE_W(LW), .LANES(NL), .FWD_DEPTH(FD), .TAG_W(TW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .out_err(out_err), .busy(busy)
  );

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [TW-1:0] tag,
                       input logic [SW-1:0] sa, input logic [SW-1:0] sb);
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    fwd_sel_a = sa;
    fwd_sel_b = sb;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [LW-1:0] lane_ref(input logic [3:0] op,
                                             input logic [LW-1:0] a,
                                             input logic [LW-1:0] b);
    int unsigned s;
    logic [2*LW-1:0] p;
    logic [LW-1:0] ones;
    s = b % LW;
    ones = '1;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a ^ b;
      4'd3:  return a + b;
      4'd4:  return a - b;
      4'd5:  return LW'($signed(a) < $signed(b));
      4'd6:  return LW'(a < b);
      4'd7:  return a << s;
      4'd8:  return a >> s;
      4'd9:  return (a >> s) | (a[LW-1] ? ~(ones >> s) : '0);
      4'd10: return a & ~b;
      4'd11: return LW'($signed(a) >= $signed(b));
      4'd12: return LW'(a >= b);
      4'd13: return LW'(a == b);
      4'd14: return LW'(a != b);
      default: begin
        p = {{LW{1'b0}}, a} * {{LW{1'b0}}, b};
        return MUL_EN ? p[LW-1:0] : '0;
      end
    endcase
  endfunction

  function automatic logic [DW-1:0] vec_ref(input logic [3:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW-1:0] r;
    for (int i = 0; i < NL; i++)
      r[i*LW +: LW] = lane_ref(op, a[i*LW +: LW], b[i*LW +: LW]);
    return r;
  endfunction

  logic [DW-1:0] mh [FD];
  logic [DW-1:0] exp_res = '0;
  logic [DW-1:0] mul_res = '0;
  logic [TW-1:0] exp_tag = '0;
  logic [TW-1:0] mul_tag = '0;
  logic          exp_valid = 1'b0;
  logic          exp_err = 1'b0;
  int            mul_cnt = 0;
  logic          exp_ready;

  function automatic logic [DW-1:0] pick(input logic [DW-1:0] v,
                                         input logic [SW-1:0] s);
    if (s == 0) return v;
    if (int'(s) <= FD) return mh[int'(s) - 1];
    return '0;
  endfunction

  assign exp_ready = (mul_cnt == 0) && (!exp_valid || out_ready) && !flush;

  always @(posedge clk) begin
    if (reset || flush) begin
      exp_valid <= 1'b0;
      mul_cnt   <= 0;
      for (int k = 0; k < FD; k++) mh[k] <= '0;
      if (reset) begin
        exp_res <= '0;
        exp_tag <= '0;
        exp_err <= 1'b0;
      end
    end else begin
      if (exp_valid && out_ready) begin
        exp_valid <= 1'b0;
        mh[0] <= exp_res;
        for (int k = 1; k < FD; k++) mh[k] <= mh[k-1];
      end
      if (in_valid && exp_ready) begin
        if (MUL_EN && in_op == 4'd15) begin
          mul_cnt <= LW;
          mul_res <= vec_ref(in_op, pick(in_a, fwd_sel_a), pick(in_b, fwd_sel_b));
          mul_tag <= in_tag;
        end else begin
          exp_valid <= 1'b1;
          exp_res <= vec_ref(in_op, pick(in_a, fwd_sel_a), pick(in_b, fwd_sel_b));
          exp_tag <= in_tag;
          exp_err <= !MUL_EN && in_op == 4'd15;
        end
      end
      if (mul_cnt != 0) begin
        mul_cnt <= mul_cnt - 1;
        if (mul_cnt == 1) begin
          exp_valid <= 1'b1;
          exp_res <= mul_res;
          exp_tag <= mul_tag;
          exp_err <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mon_out_valid", DW'(out_valid), DW'(exp_valid));
      chk("mon_busy", DW'(busy), DW'(mul_cnt != 0));
      chk("mon_in_ready", DW'(in_ready), DW'(exp_ready));
      if (exp_valid) begin
        chk("mon_result", out_result, exp_res);
        chk("mon_tag", DW'(out_tag), DW'(exp_tag));
        chk("mon_err", DW'(out_err), DW'(exp_err));
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    string         name;
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int n;
    int nb;

    tbl.push_back('{"add_nocarry", 4'd3,
      {32'd3, 32'd2, 32'd1, 32'hFFFF_FFFF}, {4{32'd1}},
      {32'd4, 32'd3, 32'd2, 32'd0}});
    tbl.push_back('{"sra", 4'd9,
      {96'd0, 32'h8000_0000}, {96'd0, 32'h24},
      {96'd0, 32'hF800_0000}});
    tbl.push_back('{"slt", 4'd5, {4{32'hFFFF_FFFF}}, {4{32'd0}}, {4{32'd1}}});
    tbl.push_back('{"sltu", 4'd6, {4{32'hFFFF_FFFF}}, {4{32'd0}}, {4{32'd0}}});
    tbl.push_back('{"sub_wrap", 4'd4,
      {32'd0, 32'd0, 32'd5, 32'd0}, {32'd1, 32'd1, 32'd3, 32'd1},
      {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF}});
    tbl.push_back('{"sll", 4'd7, {4{32'd1}},
      {32'd31, 32'h21, 32'd4, 32'd0},
      {32'h8000_0000, 32'd2, 32'h10, 32'd1}});
    tbl.push_back('{"srl", 4'd8, {4{32'h8000_0000}}, {4{32'd4}},
      {4{32'h0800_0000}}});
    tbl.push_back('{"andn", 4'd10, {4{32'hFFFF_0000}}, {4{32'h0F0F_0F0F}},
      {4{32'hF0F0_0000}}});
    tbl.push_back('{"sge", 4'd11,
      {32'hFFFF_FFFF, 32'd5, 32'd0, 32'd7},
      {32'd0, 32'd5, 32'd1, 32'hFFFF_FFFF},
      {32'd0, 32'd1, 32'd0, 32'd1}});
    tbl.push_back('{"sgeu", 4'd12,
      {32'hFFFF_FFFF, 32'd5, 32'd0, 32'd7},
      {32'd0, 32'd5, 32'd1, 32'hFFFF_FFFF},
      {32'd1, 32'd1, 32'd0, 32'd0}});
    tbl.push_back('{"seq", 4'd13, {32'd1, 32'd2, 32'd3, 32'd4},
      {32'd1, 32'd0, 32'd3, 32'd0}, {32'd1, 32'd0, 32'd1, 32'd0}});
    tbl.push_back('{"sne", 4'd14, {32'd1, 32'd2, 32'd3, 32'd4},
      {32'd1, 32'd0, 32'd3, 32'd0}, {32'd0, 32'd1, 32'd0, 32'd1}});
    tbl.push_back('{"and", 4'd0, {4{32'hF0F0_F0F0}}, {4{32'hFF00_FF00}},
      {4{32'hF000_F000}}});
    tbl.push_back('{"or", 4'd1, {4{32'hF0F0_F0F0}}, {4{32'hFF00_FF00}},
      {4{32'hFFF0_FFF0}}});
    tbl.push_back('{"xor", 4'd2, {4{32'hF0F0_F0F0}}, {4{32'hFF00_FF00}},
      {4{32'h0FF0_0FF0}}});

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_a = '0; in_b = '0; in_tag = '0; fwd_sel_a = '0; fwd_sel_b = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_out_result", out_result, '0);
    chk("rst_out_tag", DW'(out_tag), '0);
    chk("rst_out_err", DW'(out_err), '0);
    chk("rst_busy", DW'(busy), '0);
    chk_en = 1'b1;
    out_ready = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b, TW'(i), '0, '0);
      tick();
      in_valid = 1'b0;
      chk({tbl[i].name, "_valid"}, DW'(out_valid), DW'(1));
      chk(tbl[i].name, out_result, tbl[i].exp);
    end
    tick();

    // forwarding from history
    drive(4'd3, {4{32'd5}}, {4{32'd5}}, 5'd1, '0, '0);
    tick();
    in_valid = 1'b0;
    chk("fwd_base", out_result, {4{32'd10}});
    tick();
    drive(4'd3, '0, {4{32'd3}}, 5'd2, SW'(1), '0);
    tick();
    chk("fwd_hist0", out_result, {4{32'd13}});
    drive(4'd3, {4{32'hDEAD}}, {4{32'd3}}, 5'd3, SW'(7), '0);
    tick();
    in_valid = 1'b0;
    chk("fwd_out_of_range", out_result, {4{32'd3}});
    tick();

    // backpressure: result held, history frozen
    out_ready = 1'b0;
    drive(4'd0, {4{32'hFFFF_FFFF}}, {4{32'h5555_5555}}, 5'd4, '0, '0);
    tick();
    drive(4'd1, '0, '0, 5'd5, SW'(2), '0);
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_result", out_result, {4{32'h5555_5555}});
      chk("bp_in_ready_low", DW'(in_ready), '0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", DW'(in_ready), DW'(1));
    tick();
    in_valid = 1'b0;
    chk("bp_history_kept", out_result, {4{32'd13}});
    tick();

`ifdef EXEC_SIMD_ALU_MUL_EN
    drive(4'd15, {4{32'd7}}, {4{32'd6}}, 5'd6, '0, '0);
    tick();
    in_valid = 1'b0;
    in_a = '1;
    in_b = '1;
    n = 0;
    nb = 0;
    while (!out_valid && n < 40) begin
      if (busy) nb++;
      tick();
      n++;
    end
    chk("mul_latency", DW'(n), DW'(LW));
    chk("mul_busy_cycles", DW'(nb), DW'(LW));
    chk("mul_result", out_result, {4{32'd42}});
    chk("mul_busy_done", DW'(busy), '0);
    tick();

    drive(4'd15, {4{32'd7}}, {4{32'd6}}, 5'd7, '0, '0);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    drive(4'd0, '1, '1, 5'd8, '0, '0);
    #1;
    chk("flush_in_ready", DW'(in_ready), '0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy", DW'(busy), '0);
    chk("flush_out_valid", DW'(out_valid), '0);
    repeat (40) tick();
    chk("flush_no_result", DW'(out_valid), '0);

    drive(4'd15, {4{32'd3}}, {4{32'd3}}, 5'd9, '0, '0);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midmul_rst_busy", DW'(busy), '0);
    chk("midmul_rst_valid", DW'(out_valid), '0);
    chk("midmul_rst_result", out_result, '0);
    repeat (40) tick();
    chk("midmul_rst_no_result", DW'(out_valid), '0);
`else
    drive(4'd15, {4{32'd9}}, {4{32'd9}}, 5'd7, '0, '0);
    tick();
    in_valid = 1'b0;
    chk("op15_result", out_result, '0);
    chk("op15_err", DW'(out_err), DW'(1));
    drive(4'd0, {4{32'd9}}, {4{32'd3}}, 5'd8, '0, '0);
    tick();
    in_valid = 1'b0;
    chk("and_after_op15_err", DW'(out_err), '0);
    chk("and_after_op15", out_result, {4{32'd1}});
    tick();
`endif

    // randomized traffic, checked by the model
    for (int i = 0; i < 800; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_op = 4'($urandom);
      in_a = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) in_b = in_a;
      else in_b = {$urandom, $urandom, $urandom, $urandom};
      in_tag = TW'($urandom);
      fwd_sel_a = SW'($urandom_range(0, 7));
      fwd_sel_b = SW'($urandom_range(0, 7));
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 60) == 0;
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
